pixel_frame_assembler: RTL and testbench

- Receiver end of the pixel path feeding the crack-detection network (top_level).
- Accepts one pixel per cycle on a valid/ready stream with an end-of-frame marker.
- Packs each pixel into the flattened pixel_data_flat bus and presents a complete frame with a valid/ready handshake.
- Holds the frame stable until the inference side consumes it; flags short and long frames.

---
 rtl/defect_pkg.sv | 13 +
 rtl/pixel_frame_ctrl.sv | 100 ++++++++++
 rtl/pixel_frame_assembler.sv | 58 +++++
 tb/tb_pixel_frame_assembler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/defect_pkg.sv
// Shared constants and FSM encoding for the crack-detection pixel path.
package defect_pkg;

  localparam int DEF_INPUT_SIZE = 4096;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } asm_state_t;

endpackage

// File: rtl/pixel_frame_ctrl.sv
// Frame assembly control: FSM, slot counter, stream handshakes and the malformed-frame pulse.
module pixel_frame_ctrl
  import defect_pkg::*;
#(
  parameter int INPUT_SIZE = DEF_INPUT_SIZE,
  parameter int IDX_W      = $clog2(INPUT_SIZE) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             pix_last,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             frame_err,
  output logic [IDX_W-1:0] pix_count,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  asm_state_t       state_r, state_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             err_r, err_s;
  logic             accept_s;

  assign pix_ready   = (state_r != HOLD);
  assign accept_s    = pix_valid & pix_ready;
  assign frame_valid = (state_r == HOLD);
  assign frame_err   = err_r;
  assign pix_count   = idx_r;
  assign wr_en       = accept_s & (state_r == FILL);
  assign wr_idx      = idx_r;

  // State, counter and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FILL;
      idx_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      err_r   <= err_s;
    end
  end

  // Next-state and counter decode.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    err_s   = 1'b0;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          if (idx_r == LAST_IDX) begin
            // Counter reaches INPUT_SIZE either way; DRAIN clears it on exit.
            idx_s = idx_r + IDX_ONE;
            if (pix_last) begin
              state_s = HOLD;
            end else begin
              state_s = DRAIN;
              err_s   = 1'b1;
            end
          end else if (pix_last) begin
            idx_s = '0;
            err_s = 1'b1;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          state_s = FILL;
          idx_s   = '0;
        end else begin
          state_s = HOLD;
        end
      end
      DRAIN: begin
        if (accept_s && pix_last) begin
          state_s = FILL;
          idx_s   = '0;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = FILL;
        idx_s   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pixel_frame_assembler.sv
// Packs a pixel stream into a flat frame buffer and hands complete frames to the inference side.
module pixel_frame_assembler
  import defect_pkg::*;
#(
  parameter int INPUT_SIZE = DEF_INPUT_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IDX_W      = $clog2(INPUT_SIZE) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic [DATA_WIDTH-1:0]          pix_data,
  input  logic                           pix_last,
  output logic [DATA_WIDTH*INPUT_SIZE-1:0] pixel_data_flat,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic                           frame_err,
  output logic [IDX_W-1:0]               pix_count
);

  logic             wr_en_s;
  logic [IDX_W-1:0] wr_idx_s;

  pixel_frame_ctrl #(
    .INPUT_SIZE (INPUT_SIZE),
    .IDX_W      (IDX_W)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_last    (pix_last),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_err   (frame_err),
    .pix_count   (pix_count),
    .wr_en       (wr_en_s),
    .wr_idx      (wr_idx_s)
  );

  // One register per slot, each enabled by its own index decode.
  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_slot
    logic [DATA_WIDTH-1:0] slot_r;

    // Slot write on a FILL-state accept addressed to this index.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_r <= '0;
      end else if (wr_en_s && (wr_idx_s == IDX_W'(i))) begin
        slot_r <= pix_data;
      end
    end

    assign pixel_data_flat[i*DATA_WIDTH +: DATA_WIDTH] = slot_r;
  end

endmodule

// File: tb/tb_pixel_frame_assembler.sv
// Directed bench for pixel_frame_assembler at a 4-pixel frame size.
module tb_pixel_frame_assembler;

  localparam int INPUT_SIZE = 4;
  localparam int DATA_WIDTH = 8;
  localparam int IDX_W      = $clog2(INPUT_SIZE) + 1;

  logic                             clk;
  logic                             rst;
  logic                             pix_valid;
  logic                             pix_ready;
  logic [DATA_WIDTH-1:0]            pix_data;
  logic                             pix_last;
  logic [DATA_WIDTH*INPUT_SIZE-1:0] pixel_data_flat;
  logic                             frame_valid;
  logic                             frame_ready;
  logic                             frame_err;
  logic [IDX_W-1:0]                 pix_count;

  int n_checks;
  int n_pass;

  pixel_frame_assembler #(
    .INPUT_SIZE (INPUT_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_data        (pix_data),
    .pix_last        (pix_last),
    .pixel_data_flat (pixel_data_flat),
    .frame_valid     (frame_valid),
    .frame_ready     (frame_ready),
    .frame_err       (frame_err),
    .pix_count       (pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_pix(input logic [7:0] d, input logic l);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = l;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic consume();
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
  endtask

  logic [7:0]  gap_data [4];
  logic [31:0] held;

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    pix_valid   = 1'b0;
    pix_data    = 8'h00;
    pix_last    = 1'b0;
    frame_ready = 1'b0;
    #12;
    check_val("rst_flat",  pixel_data_flat, 32'h0);
    check_val("rst_valid", {31'd0, frame_valid}, 32'd0);
    check_val("rst_err",   {31'd0, frame_err}, 32'd0);
    check_val("rst_count", {29'd0, pix_count}, 32'd0);
    check_val("rst_ready", {31'd0, pix_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Nominal frame
    send_pix(8'h11, 1'b0);
    check_val("nom_count1", {29'd0, pix_count}, 32'd1);
    send_pix(8'h22, 1'b0);
    send_pix(8'h33, 1'b0);
    check_val("nom_err", {31'd0, frame_err}, 32'd0);
    send_pix(8'h44, 1'b1);
    check_val("nom_valid", {31'd0, frame_valid}, 32'd1);
    check_val("nom_flat",  pixel_data_flat, 32'h44332211);
    check_val("nom_count", {29'd0, pix_count}, 32'd4);
    check_val("nom_err2",  {31'd0, frame_err}, 32'd0);

    // Backpressure: frame held, stream stalled
    pix_valid = 1'b1;
    pix_data  = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check_val("bp_ready", {31'd0, pix_ready}, 32'd0);
      check_val("bp_flat",  pixel_data_flat, 32'h44332211);
    end
    pix_valid = 1'b0;
    consume();
    check_val("bp_valid_drop", {31'd0, frame_valid}, 32'd0);
    check_val("bp_ready_back", {31'd0, pix_ready}, 32'd1);
    check_val("bp_count",      {29'd0, pix_count}, 32'd0);

    // Short frame
    send_pix(8'hAA, 1'b0);
    send_pix(8'hBB, 1'b1);
    check_val("short_err",   {31'd0, frame_err}, 32'd1);
    check_val("short_valid", {31'd0, frame_valid}, 32'd0);
    check_val("short_count", {29'd0, pix_count}, 32'd0);
    check_val("short_flat",  pixel_data_flat, 32'h4433BBAA);
    idle(1);
    check_val("short_err_pulse", {31'd0, frame_err}, 32'd0);
    check_val("short_valid2",    {31'd0, frame_valid}, 32'd0);
    send_pix(8'h01, 1'b0);
    send_pix(8'h02, 1'b0);
    send_pix(8'h03, 1'b0);
    send_pix(8'h04, 1'b1);
    check_val("after_short_valid", {31'd0, frame_valid}, 32'd1);
    check_val("after_short_flat",  pixel_data_flat, 32'h04030201);
    consume();

    // Long frame: error after the 4th accept, extras dropped
    send_pix(8'h05, 1'b0);
    send_pix(8'h06, 1'b0);
    send_pix(8'h07, 1'b0);
    check_val("long_err_early", {31'd0, frame_err}, 32'd0);
    send_pix(8'h08, 1'b0);
    check_val("long_err",   {31'd0, frame_err}, 32'd1);
    check_val("long_valid", {31'd0, frame_valid}, 32'd0);
    check_val("long_flat",  pixel_data_flat, 32'h08070605);
    send_pix(8'h09, 1'b0);
    check_val("long_err_once", {31'd0, frame_err}, 32'd0);
    check_val("long_drain_rdy", {31'd0, pix_ready}, 32'd1);
    send_pix(8'h0A, 1'b1);
    check_val("long_flat2",  pixel_data_flat, 32'h08070605);
    check_val("long_valid2", {31'd0, frame_valid}, 32'd0);
    check_val("long_err2",   {31'd0, frame_err}, 32'd0);
    check_val("long_count",  {29'd0, pix_count}, 32'd0);
    send_pix(8'h31, 1'b0);
    send_pix(8'h32, 1'b0);
    send_pix(8'h33, 1'b0);
    send_pix(8'h34, 1'b1);
    check_val("after_long_flat",  pixel_data_flat, 32'h34333231);
    check_val("after_long_valid", {31'd0, frame_valid}, 32'd1);
    consume();

    // Asynchronous reset between edges, mid-frame
    send_pix(8'hC1, 1'b0);
    send_pix(8'hC2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_count", {29'd0, pix_count}, 32'd0);
    check_val("arst_flat",  pixel_data_flat, 32'h0);
    check_val("arst_valid", {31'd0, frame_valid}, 32'd0);
    check_val("arst_err",   {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_pix(8'hD1, 1'b0);
    send_pix(8'hD2, 1'b0);
    send_pix(8'hD3, 1'b0);
    send_pix(8'hD4, 1'b1);
    check_val("arst_frame_flat",  pixel_data_flat, 32'hD4D3D2D1);
    check_val("arst_frame_valid", {31'd0, frame_valid}, 32'd1);
    consume();

    // Random pix_valid gaps; frame_valid must rise only right after the last accept
    gap_data[0] = 8'h5A;
    gap_data[1] = 8'hC3;
    gap_data[2] = 8'h0F;
    gap_data[3] = 8'hF0;
    for (int p = 0; p < 4; p++) begin
      idle(int'($urandom_range(0, 3)));
      check_val("gap_valid_low", {31'd0, frame_valid}, 32'd0);
      send_pix(gap_data[p], (p == 3) ? 1'b1 : 1'b0);
    end
    check_val("gap_valid", {31'd0, frame_valid}, 32'd1);
    check_val("gap_flat",  pixel_data_flat, 32'hF00FC35A);
    held = 32'hF00FC35A;
    idle(3);
    check_val("gap_hold_flat", pixel_data_flat, held);
    consume();
    check_val("gap_done_valid", {31'd0, frame_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
